// File: rtl/frame_readout.sv
// Frame readout: fetches the most recently completed ping-pong frame from DDR in
// bursts, buffers it in a pixel FIFO and streams RGB565 pixels with SOF/EOL markers.
module frame_readout #(
  parameter int          MEM_DATA_LEN = 64,
  parameter int          ADDR_LEN     = 32,
  parameter int          VIDEO_WIDTH  = 960,
  parameter int          VIDEO_HEIGHT = 540,
  parameter int          BURST_LEN    = 16,
  parameter int          FIFO_DEPTH   = 64,
  parameter int unsigned BUF_A_BASE   = 4147200,
  parameter int unsigned BUF_B_BASE   = 6220800
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    image_addr_flag,
  input  logic                    frame_start,
  output logic                    rd_valid,
  input  logic                    rd_ready,
  output logic [9:0]              rd_burst_len,
  output logic [ADDR_LEN-1:0]     rd_addr,
  input  logic [MEM_DATA_LEN-1:0] rd_data,
  input  logic                    rd_burst_finish,
  output logic                    pix_valid,
  input  logic                    pix_ready,
  output logic [15:0]             pix_data,
  output logic                    pix_sof,
  output logic                    pix_eol,
  output logic                    busy,
  output logic                    underflow
);
  localparam logic [31:0]      IMAGE_SIZE = 32'(VIDEO_WIDTH * VIDEO_HEIGHT);
  localparam int               PTR_W      = $clog2(FIFO_DEPTH);
  localparam int               CNT_W      = PTR_W + 1;
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);
  localparam logic [10:0]      LAST_X     = 11'(VIDEO_WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_LATCH, S_CHECK, S_READ, S_DRAIN} state_t;

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] base_q, base_d, rd_addr_q, rd_addr_d;
  logic [31:0]         fetch_cnt_q, fetch_cnt_d, pix_cnt_q, pix_cnt_d;
  logic [10:0]         pix_x_q, pix_x_d;
  logic [9:0]          pix_y_q, pix_y_d, rd_burst_len_q, rd_burst_len_d;
  logic                rd_valid_q, rd_valid_d, busy_q, busy_d;
  logic                underflow_q, underflow_d, restart_q, restart_d;
  logic [PTR_W-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [15:0]         fifo_mem [FIFO_DEPTH];

  logic        push, pop, drop, stall;
  logic [31:0] remaining, free;
  logic [9:0]  len;

  assign pix_valid = (count_q != '0);
  assign pop       = pix_valid && pix_ready;

  // NOTE: every variable gets a default before any branch, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    base_d         = base_q;
    rd_addr_d      = rd_addr_q;
    fetch_cnt_d    = fetch_cnt_q;
    pix_cnt_d      = pix_cnt_q;
    pix_x_d        = pix_x_q;
    pix_y_d        = pix_y_q;
    rd_burst_len_d = rd_burst_len_q;
    rd_valid_d     = rd_valid_q;
    busy_d         = busy_q;
    restart_d      = restart_q;
    wr_ptr_d       = wr_ptr_q;
    rd_ptr_d       = rd_ptr_q;
    push           = 1'b0;
    drop           = 1'b0;
    remaining      = IMAGE_SIZE - fetch_cnt_q;
    len            = (remaining < 32'(BURST_LEN)) ? remaining[9:0] : 10'(BURST_LEN);
    free           = 32'(FIFO_FULL - count_q);
    stall          = busy_q && pix_ready && !pix_valid && (pix_cnt_q < IMAGE_SIZE)
                     && (state_q != S_LATCH);

    if (pop) begin
      pix_cnt_d = pix_cnt_q + 32'd1;
      rd_ptr_d  = rd_ptr_q + PTR_W'(1);
      if (pix_x_q == LAST_X) begin
        pix_x_d = '0;
        pix_y_d = pix_y_q + 10'd1;
      end else begin
        pix_x_d = pix_x_q + 11'd1;
      end
    end

    // A beat that finds the FIFO full means the CHECK sizing was violated.
    if (state_q == S_READ && rd_ready) begin
      if (count_q == FIFO_FULL) drop = 1'b1;
      else                      push = 1'b1;
    end
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    count_d = count_q + CNT_W'(push) - CNT_W'(pop);

    unique case (state_q)
      S_IDLE: if (frame_start) state_d = S_LATCH;
      S_LATCH: begin
        // Read the buffer the processing stage is not writing.
        base_d      = image_addr_flag ? ADDR_LEN'(BUF_B_BASE) : ADDR_LEN'(BUF_A_BASE);
        fetch_cnt_d = '0;
        pix_cnt_d   = '0;
        pix_x_d     = '0;
        pix_y_d     = '0;
        wr_ptr_d    = '0;
        rd_ptr_d    = '0;
        count_d     = '0;
        busy_d      = 1'b1;
        restart_d   = 1'b0;
        state_d     = S_CHECK;
      end
      S_CHECK: begin
        if (frame_start) begin
          state_d = S_LATCH;
        end else if (fetch_cnt_q == IMAGE_SIZE) begin
          state_d = S_DRAIN;
        end else if (free >= 32'(len)) begin
          rd_addr_d      = base_q + ADDR_LEN'(fetch_cnt_q);
          rd_burst_len_d = len;
          rd_valid_d     = 1'b1;
          state_d        = S_READ;
        end
      end
      S_READ: begin
        // A burst in flight always completes; a restart waits for its finish.
        if (frame_start) restart_d = 1'b1;
        if (rd_burst_finish) begin
          rd_valid_d = 1'b0;
          if (restart_q || frame_start) begin
            restart_d = 1'b0;
            state_d   = S_LATCH;
          end else begin
            fetch_cnt_d = fetch_cnt_q + 32'(rd_burst_len_q);
            state_d     = S_CHECK;
          end
        end
      end
      S_DRAIN: begin
        if (frame_start) begin
          state_d = S_LATCH;
        end else if (pix_cnt_q == IMAGE_SIZE) begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    underflow_d = underflow_q | stall | drop;
  end

  // NOTE: sequential state is updated only with non-blocking assignments so all
  // flops see the same pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q        <= S_IDLE;
      base_q         <= '0;
      rd_addr_q      <= '0;
      fetch_cnt_q    <= '0;
      pix_cnt_q      <= '0;
      pix_x_q        <= '0;
      pix_y_q        <= '0;
      rd_burst_len_q <= 10'(BURST_LEN);
      rd_valid_q     <= 1'b0;
      busy_q         <= 1'b0;
      underflow_q    <= 1'b0;
      restart_q      <= 1'b0;
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      count_q        <= '0;
    end else begin
      state_q        <= state_d;
      base_q         <= base_d;
      rd_addr_q      <= rd_addr_d;
      fetch_cnt_q    <= fetch_cnt_d;
      pix_cnt_q      <= pix_cnt_d;
      pix_x_q        <= pix_x_d;
      pix_y_q        <= pix_y_d;
      rd_burst_len_q <= rd_burst_len_d;
      rd_valid_q     <= rd_valid_d;
      busy_q         <= busy_d;
      underflow_q    <= underflow_d;
      restart_q      <= restart_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      count_q        <= count_d;
    end
  end

  // NOTE: pixel storage has no reset; count and pointers alone decide which
  // entries are meaningful, and pix_data is forced to zero while empty.
  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr_q] <= rd_data[15:0];
  end

  assign rd_valid     = rd_valid_q;
  assign rd_addr      = rd_addr_q;
  assign rd_burst_len = rd_burst_len_q;
  assign busy         = busy_q;
  assign underflow    = underflow_q;
  assign pix_data     = pix_valid ? fifo_mem[rd_ptr_q] : 16'h0000;
  assign pix_sof      = pix_valid && (pix_cnt_q == 32'd0);
  assign pix_eol      = pix_valid && (pix_x_q == LAST_X);

  // Upper memory bits carry no pixel data; the line counter is kept for debug.
  logic unused_bits;
  assign unused_bits = ^{pix_y_q, rd_data[MEM_DATA_LEN-1:16]};
endmodule

// File: tb/tb_frame_readout.sv
// Bench for frame_readout: an 8x4 and a 6x3 instance, each with a burst memory
// model (word = address) and a pixel monitor, checked against directed vectors.
module tb_frame_readout;
  localparam logic [31:0] BUF_A = 32'd4147200;
  localparam logic [31:0] BUF_B = 32'd6220800;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] frame_start, image_addr_flag, rdy_always, rdy_gated;
  logic [1:0] busy_v, underflow_v, rd_valid_v, pix_valid_v;
  int         mem_delay [2];
  int         n_checks = 0;
  int         n_fail   = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_i
    localparam int W = (g == 0) ? 8 : 6;
    localparam int H = (g == 0) ? 4 : 3;
    logic        rd_valid, rd_ready, rd_burst_finish, pix_valid, pix_ready;
    logic        pix_sof, pix_eol, busy, underflow;
    logic [9:0]  rd_burst_len;
    logic [31:0] rd_addr;
    logic [63:0] rd_data;
    logic [15:0] pix_data;
    logic [31:0] b_addr [$];
    int          b_len [$];
    int          b_pops [$];
    logic [15:0] p_data [$];
    bit          p_sof [$];
    bit          p_eol [$];
    int          pops  = 0;
    int          drops = 0;

    // Gated mode only raises ready alongside valid, so it never counts as a stall.
    assign pix_ready      = rdy_always[g] | (rdy_gated[g] & pix_valid);
    assign busy_v[g]      = busy;
    assign underflow_v[g] = underflow;
    assign rd_valid_v[g]  = rd_valid;
    assign pix_valid_v[g] = pix_valid;

    frame_readout #(
      .VIDEO_WIDTH(W), .VIDEO_HEIGHT(H), .BURST_LEN(4), .FIFO_DEPTH(8)
    ) u_dut (
      .clk(clk), .rst(rst), .image_addr_flag(image_addr_flag[g]),
      .frame_start(frame_start[g]), .rd_valid(rd_valid), .rd_ready(rd_ready),
      .rd_burst_len(rd_burst_len), .rd_addr(rd_addr), .rd_data(rd_data),
      .rd_burst_finish(rd_burst_finish), .pix_valid(pix_valid), .pix_ready(pix_ready),
      .pix_data(pix_data), .pix_sof(pix_sof), .pix_eol(pix_eol), .busy(busy),
      .underflow(underflow)
    );

    initial begin : mem_model
      logic        active;
      logic [31:0] addr;
      int          idx, len, wait_cnt;
      active = 1'b0; addr = '0; idx = 0; len = 0; wait_cnt = 0;
      rd_ready = 1'b0; rd_burst_finish = 1'b0; rd_data = '0;
      forever begin
        @(negedge clk);
        rd_ready        = 1'b0;
        rd_burst_finish = 1'b0;
        if (!rst) begin
          active = 1'b0;
        end else if (active) begin
          if (!rd_valid) drops++;
          if (wait_cnt > 0) begin
            wait_cnt--;
          end else begin
            rd_ready = 1'b1;
            rd_data  = {32'hDEAD_BEEF, addr + 32'(idx)};
            idx++;
            if (idx == len) begin
              rd_burst_finish = 1'b1;
              active          = 1'b0;
            end
          end
        end else if (rd_valid) begin
          addr = rd_addr; len = int'(rd_burst_len); idx = 0;
          wait_cnt = mem_delay[g]; active = 1'b1;
          b_addr.push_back(rd_addr); b_len.push_back(len); b_pops.push_back(pops);
        end
      end
    end

    initial begin : monitor
      forever begin
        @(negedge clk);
        if (rst && pix_valid && pix_ready) begin
          p_data.push_back(pix_data); p_sof.push_back(pix_sof); p_eol.push_back(pix_eol);
          pops++;
        end
      end
    end
  end

  function automatic int px_n(input int k);
    return (k == 0) ? g_i[0].p_data.size() : g_i[1].p_data.size();
  endfunction
  function automatic int b_n(input int k);
    return (k == 0) ? g_i[0].b_addr.size() : g_i[1].b_addr.size();
  endfunction
  function automatic logic [15:0] px_d(input int k, input int i);
    return (k == 0) ? g_i[0].p_data[i] : g_i[1].p_data[i];
  endfunction
  function automatic bit px_s(input int k, input int i);
    return (k == 0) ? g_i[0].p_sof[i] : g_i[1].p_sof[i];
  endfunction
  function automatic bit px_e(input int k, input int i);
    return (k == 0) ? g_i[0].p_eol[i] : g_i[1].p_eol[i];
  endfunction
  function automatic logic [31:0] b_a(input int k, input int i);
    return (k == 0) ? g_i[0].b_addr[i] : g_i[1].b_addr[i];
  endfunction
  function automatic int b_l(input int k, input int i);
    return (k == 0) ? g_i[0].b_len[i] : g_i[1].b_len[i];
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns two cycles later with the frame latched.
  task automatic pulse_start(input int k);
    frame_start[k] = 1'b1;
    @(posedge clk); #1;
    frame_start[k] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_frame(input int k, input string name);
    int n = 0;
    while (busy_v[k] && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, " busy falls"}, 64'(busy_v[k]), 64'd0);
  endtask

  task automatic check_frame(input string name, input int k, input int b0, input int p0,
                             input int nb, input int npix, input int w, input int last_len,
                             input logic [31:0] base);
    logic [31:0] a;
    check({name, " bursts"}, 64'(b_n(k) - b0), 64'(nb));
    for (int i = 0; i < nb && b0 + i < b_n(k); i++) begin
      check($sformatf("%s addr%0d", name, i), 64'(b_a(k, b0 + i)), 64'(base + 32'(4 * i)));
      check($sformatf("%s len%0d", name, i), 64'(b_l(k, b0 + i)),
            64'((i == nb - 1) ? last_len : 4));
    end
    check({name, " pixels"}, 64'(px_n(k) - p0), 64'(npix));
    for (int i = 0; i < npix && p0 + i < px_n(k); i++) begin
      a = base + 32'(i);
      check($sformatf("%s data%0d", name, i), 64'(px_d(k, p0 + i)), 64'(a[15:0]));
      check($sformatf("%s sof%0d", name, i), 64'(px_s(k, p0 + i)), 64'(i == 0));
      check($sformatf("%s eol%0d", name, i), 64'(px_e(k, p0 + i)), 64'((i % w) == w - 1));
    end
  endtask

  typedef struct {
    string       name;
    int          inst;
    logic        flag;
    logic        flip;
    int          nb;
    int          npix;
    int          w;
    int          last_len;
    logic [31:0] base;
  } frame_vec_t;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin : main
    frame_vec_t vecs [3];
    int nb0, np0, pops_en, n, sofs, last_sof;

    vecs[0] = '{"frame_a", 0, 1'b0, 1'b0, 8, 32, 8, 4, BUF_A};
    vecs[1] = '{"frame_b", 0, 1'b1, 1'b1, 8, 32, 8, 4, BUF_B};
    vecs[2] = '{"odd_size", 1, 1'b0, 1'b0, 5, 18, 6, 2, BUF_A};

    rst = 1'b0; frame_start = '0; image_addr_flag = '0;
    rdy_always = '0; rdy_gated = '0; mem_delay[0] = 0; mem_delay[1] = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst rd_valid", 64'(g_i[0].rd_valid), 64'd0);
    check("rst rd_burst_len", 64'(g_i[0].rd_burst_len), 64'd4);
    check("rst rd_addr", 64'(g_i[0].rd_addr), 64'd0);
    check("rst pix_valid", 64'(g_i[0].pix_valid), 64'd0);
    check("rst pix_data", 64'(g_i[0].pix_data), 64'd0);
    check("rst pix_sof", 64'(g_i[0].pix_sof), 64'd0);
    check("rst pix_eol", 64'(g_i[0].pix_eol), 64'd0);
    check("rst busy", 64'(g_i[0].busy), 64'd0);
    check("rst underflow", 64'(g_i[0].underflow), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    for (int v = 0; v < 3; v++) begin
      nb0 = b_n(vecs[v].inst);
      np0 = px_n(vecs[v].inst);
      image_addr_flag[vecs[v].inst] = vecs[v].flag;
      rdy_gated[vecs[v].inst] = 1'b1;
      pulse_start(vecs[v].inst);
      if (vecs[v].flip) begin
        repeat (10) @(posedge clk);
        #1;
        image_addr_flag[vecs[v].inst] = ~vecs[v].flag;
      end
      wait_frame(vecs[v].inst, vecs[v].name);
      check_frame(vecs[v].name, vecs[v].inst, nb0, np0, vecs[v].nb, vecs[v].npix,
                  vecs[v].w, vecs[v].last_len, vecs[v].base);
      check({vecs[v].name, " underflow"}, 64'(underflow_v[vecs[v].inst]), 64'd0);
      rdy_gated[vecs[v].inst] = 1'b0;
    end

    // Consumer stalled: two bursts fill the FIFO, then fetching must pause.
    nb0 = b_n(0); np0 = px_n(0);
    image_addr_flag[0] = 1'b0;
    pulse_start(0);
    repeat (40) @(posedge clk);
    #1;
    check("stall bursts", 64'(b_n(0) - nb0), 64'd2);
    check("stall rd_valid", 64'(rd_valid_v[0]), 64'd0);
    check("stall pix_valid", 64'(pix_valid_v[0]), 64'd1);
    check("stall busy", 64'(busy_v[0]), 64'd1);
    pops_en = g_i[0].pops;
    rdy_gated[0] = 1'b1;
    wait_frame(0, "stall");
    if (b_n(0) > nb0 + 2) begin
      n = g_i[0].b_pops[nb0 + 2] - pops_en;
      check("stall third burst waits for 4 free", 64'(n >= 4 && n <= 6), 64'd1);
    end
    check_frame("stall", 0, nb0, np0, 8, 32, 8, 4, BUF_A);
    check("stall underflow", 64'(underflow_v[0]), 64'd0);

    // Restart while the second burst is in flight.
    nb0 = b_n(0); np0 = px_n(0);
    mem_delay[0] = 3;
    pulse_start(0);
    n = 0;
    while (b_n(0) < nb0 + 2 && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("restart second burst seen", 64'(b_n(0) >= nb0 + 2), 64'd1);
    pulse_start(0);
    wait_frame(0, "restart");
    check("restart rd_valid held", 64'(g_i[0].drops), 64'd0);
    sofs = 0; last_sof = np0;
    for (int i = np0; i < px_n(0); i++) begin
      if (px_s(0, i)) begin
        sofs++;
        last_sof = i;
      end
    end
    check("restart sof count", 64'(sofs), 64'd2);
    check_frame("restart", 0, nb0 + 2, last_sof, 8, 32, 8, 4, BUF_A);
    check("restart underflow", 64'(underflow_v[0]), 64'd0);

    // Consumer pulls on an empty FIFO while memory is slow: sticky underflow.
    nb0 = b_n(0); np0 = px_n(0);
    mem_delay[0] = 5; rdy_gated[0] = 1'b0; rdy_always[0] = 1'b1;
    pulse_start(0);
    wait_frame(0, "underrun");
    check_frame("underrun", 0, nb0, np0, 8, 32, 8, 4, BUF_A);
    check("underrun underflow set", 64'(underflow_v[0]), 64'd1);
    mem_delay[0] = 0; rdy_always[0] = 1'b0; rdy_gated[0] = 1'b1;
    pulse_start(0);
    wait_frame(0, "sticky");
    check("underflow sticky", 64'(underflow_v[0]), 64'd1);
    rst = 1'b0;
    #3;
    check("underflow cleared by rst", 64'(underflow_v[0]), 64'd0);
    rst = 1'b1;
    repeat (2) @(posedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_readout.md
Name: frame_readout

Overview:
- Downstream stage of the frame-processing block.
- Fetches the most recently completed processed frame from DDR through the burst read port, and buffers pixels in an internal FIFO.
- Streams pixels with valid/ready and frame/line markers to the display output path; operates entirely in clk (mem_clk).
- Selects the ping-pong buffer from the processing block's image_addr_flag.

Parameters:
- MEM_DATA_LEN, 64: memory word width; one word per pixel, pixel in bits [15:0] (RGB565).
- ADDR_LEN, 32: memory address width; address unit is one word.
- VIDEO_WIDTH, 960: pixels per line.
- VIDEO_HEIGHT, 540: lines per frame.
- BURST_LEN, 16: maximum words per read burst (1..FIFO_DEPTH).
- FIFO_DEPTH, 64: pixel FIFO entries (power of 2).
- BUF_A_BASE, 4147200: buffer written while image_addr_flag=1.
- BUF_B_BASE, 6220800: buffer written while image_addr_flag=0.

Ports:
- clk  in  1  memory/system clock.
- rst  in  1  asynchronous, active-low reset.
- image_addr_flag  in  1  ping-pong flag from the processing stage.
- frame_start  in  1  single-cycle pulse; the display needs a new frame (already synchronised to clk).
- rd_valid  out  1  read request, held until rd_burst_finish.
- rd_ready  in  1  rd_data valid this cycle (one beat).
- rd_burst_len  out  10  words in the current burst.
- rd_addr  out  ADDR_LEN  burst start address.
- rd_data  in  MEM_DATA_LEN  read data.
- rd_burst_finish  in  1  burst complete pulse.
- pix_valid  out  1  pix_data valid (FIFO non-empty, show-ahead).
- pix_ready  in  1  consumer accepts pixel.
- pix_data  out  16  pixel.
- pix_sof  out  1  qualifies pixel (0,0).
- pix_eol  out  1  qualifies the last pixel of a line.
- busy  out  1  frame fetch in progress.
- underflow  out  1  sticky: consumer stalled on an empty FIFO mid-frame.

Behaviour:
- Reset values: rd_valid=0, rd_burst_len=BURST_LEN, rd_addr=0, pix_valid=0, pix_data=0, pix_sof=0, pix_eol=0, busy=0, underflow=0. FIFO empty, counters zero, state IDLE.
- Constants: IMAGE_SIZE=VIDEO_WIDTH*VIDEO_HEIGHT. fetch_cnt and pix_cnt are 32 bits; pix_x is 11 bits and pix_y is 10 bits.
- IDLE: wait for frame_start, then go to LATCH.
- LATCH (1 cycle):
  - base = image_addr_flag ? BUF_B_BASE : BUF_A_BASE, i.e. the buffer not currently being written.
  - Clear fetch_cnt, pix_cnt, pix_x, pix_y; flush the FIFO; busy=1.
  - Go to CHECK.
- CHECK:
  - If fetch_cnt==IMAGE_SIZE, go to DRAIN.
  - Otherwise len = min(BURST_LEN, IMAGE_SIZE-fetch_cnt).
  - If FIFO free entries >= len: rd_addr=base+fetch_cnt, rd_burst_len=len, rd_valid=1 on the next edge, go to READ.
  - Otherwise stay in CHECK.
- READ:
  - Each cycle with rd_ready=1 pushes rd_data[15:0] into the FIFO.
  - Free space is guaranteed by the check in CHECK; a push to a full FIFO is dropped and sets underflow (treated as an error).
  - On rd_burst_finish: rd_valid=0, fetch_cnt+=len, go to CHECK.
  - A rd_ready on the same cycle as rd_burst_finish is still pushed.
- DRAIN: wait until pix_cnt==IMAGE_SIZE, then busy=0 and go to IDLE.
- frame_start in CHECK, DRAIN or IDLE: go to LATCH immediately.
- frame_start in READ:
  - Latch restart_pending; the current burst runs to rd_burst_finish, since memory transactions are never abandoned.
  - Then go to LATCH instead of CHECK.
  - Data from that burst is discarded by the flush.
- Output side:
  - pix_valid = FIFO non-empty. Transfer happens when pix_valid && pix_ready; pix_data is the FIFO head.
  - On a transfer: pix_cnt++, pix_x++. At pix_x==VIDEO_WIDTH-1, pix_x wraps to 0 and pix_y++.
  - pix_sof = pix_valid && pix_cnt==0. pix_eol = pix_valid && pix_x==VIDEO_WIDTH-1.
- underflow set when busy && pix_ready && !pix_valid && pix_cnt<IMAGE_SIZE && state!=LATCH. Cleared only by rst.
- Simultaneous FIFO push and pop in one cycle: occupancy is unchanged.
- Pop of the last pixel while frame_start arrives: the flush wins and pix_cnt clears.
- image_addr_flag is sampled only in LATCH; changes mid-frame are ignored.
- Latency:
  - frame_start to rd_valid: 3 cycles (LATCH, CHECK, issue).
  - rd_ready beat to pix_valid: 1 cycle.

Test Plan:
Bench parameters: VIDEO_WIDTH=8, VIDEO_HEIGHT=4, BURST_LEN=4, FIFO_DEPTH=8, memory model word = address.
- Reset, then frame_start with flag=0 and pix_ready=1 → bursts at 4147200, +4, ... +28, each with len=4. Pixels equal addr[15:0] in order; pix_sof on the first pixel; pix_eol every 8th pixel; 32 pixels total; busy falls; underflow=0.
- flag=1, frame_start → first rd_addr=6220800. Toggling flag mid-frame does not change base.
- pix_ready=0 → after 2 bursts the FIFO is full (8 entries) and rd_valid stays 0. Raise pix_ready → the next burst issues only once free>=4.
- VIDEO_WIDTH=6, HEIGHT=3, BURST_LEN=4 → bursts of len 4,4,4,4,2 with final rd_addr=base+16; 18 pixels delivered.
- frame_start during READ (mid-burst) → rd_valid held until rd_burst_finish, then a new LATCH. Next rd_addr=base+0; first pixel out carries pix_sof with value base[15:0].
- Memory model delays rd_ready while pix_ready=1 on an empty FIFO → underflow=1 and stays 1 through the next frame until rst.
